afu_rd_arbiter: RTL
===================

AFU_RD_ARBITER -- requirements
Module: afu_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ORD_DEPTH, default 8, order-FIFO depth in entries (power of 2).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester read request pending.
REQ-006 SHALL have port req_addr, input, NUM_REQ*58, per-requester CL address; slice i is [58*i+57:58*i].
REQ-007 SHALL have port req_len, input, NUM_REQ*6, per-requester length in CL; 0 means 64.
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot grant; combinational, same cycle as acceptance.
REQ-009 SHALL have port spl_tx_rd_almostfull, input, 1, TX read channel backpressure.
REQ-010 SHALL have port cor_tx_rd_valid, output, 1, read request to afu_io.
REQ-011 SHALL have port cor_tx_rd_addr, output, 58, read request address.
REQ-012 SHALL have port cor_tx_rd_len, output, 6, read request length.
REQ-013 SHALL have port io_rx_rd_valid, input, 1, one returned CL.
REQ-014 SHALL have port io_rx_data, input, 512, returned CL data.
REQ-015 SHALL have port rsp_valid, output, NUM_REQ, one-hot response strobe to the owning requester.
REQ-016 SHALL have port rsp_data, output, 512, response data shared by all requesters.
REQ-017 SHALL have port busy, output, 1, high while any granted request has CLs outstanding.
REQ-018 SHALL have port err, output, 1, sticky: response received with the order FIFO empty.

Function
REQ-019 Acceptance SHALL occur in a cycle when spl_tx_rd_almostfull=0, order FIFO not full, and any req_valid=1.
REQ-020 Grant SHALL be round-robin: the lowest index strictly after the last granted index, wrapping to 0; pointer reset value is NUM_REQ-1, so requester 0 has first priority.
REQ-021 On acceptance req_ready SHALL assert for exactly the granted index; a requester holds valid/addr/len stable until ready.
REQ-022 cor_tx_rd_valid/addr/len SHALL be registered: asserted the cycle after acceptance, for one cycle per accepted request.
REQ-023 On acceptance SHALL push {grant index, CL count} to the order FIFO; len 0 is stored as count 64 (7-bit).
REQ-024 Responses SHALL be assumed in request order, one CL per io_rx_rd_valid cycle; each is routed to the head entry's index.
REQ-025 rsp_valid[head] and rsp_data SHALL be registered: one cycle after io_rx_rd_valid; rsp_data holds its last value otherwise.
REQ-026 Each response SHALL decrement the head remaining count; the head pops on the response that brings it from 1 to 0.
REQ-027 Full SHALL be evaluated from the registered count: when full, no acceptance that cycle, even if a pop occurs the same cycle.
REQ-028 Simultaneous push and pop SHALL be supported when not full; occupancy stays unchanged.
REQ-029 When io_rx_rd_valid=1 with the FIFO empty, SHALL raise err; rsp_valid stays 0 and the response is dropped.
REQ-030 busy SHALL equal (FIFO occupancy != 0).
REQ-031 Requests from a requester whose req_valid falls before grant SHALL be dropped without a round-robin pointer update.

Reset
REQ-032 While reset_n=0 at a clock edge: FIFO empty, pointer=NUM_REQ-1, and all outputs 0, except rsp_data which holds 0 as well.
REQ-033 Reset mid-operation SHALL discard all outstanding entries; responses arriving after reset, with the FIFO empty, set err.
REQ-034 req_ready SHALL be 0 while reset_n=0.

Verification
REQ-035 req_valid=4'b1111 held, almostfull=0, len=1 each -> grants 0,1,2,3,0 on consecutive cycles; cor_tx_rd_valid follows each by 1 cycle.
REQ-036 Requester 2 len=0 (64 CL), then requester 1 len=2; 66 io_rx_rd_valid pulses -> 64 rsp_valid[2], then 2 rsp_valid[1]; busy drops after the 66th.
REQ-037 8 accepted requests, no responses -> 9th is not granted (req_ready=0); one full head completion frees the slot, and the next acceptance follows the next cycle.
REQ-038 spl_tx_rd_almostfull=1 with req_valid=4'b0101 -> no req_ready, no cor_tx_rd_valid; on release, requester 0 is granted first.
REQ-039 io_rx_rd_valid with FIFO empty -> err=1, sticky until reset_n=0; rsp_valid=0.
REQ-040 Reset asserted with 3 entries outstanding -> busy=0 next cycle; the next grant goes to requester 0.

Source files
------------

// File: rtl/afu_rd_arbiter.sv
// Round-robin read arbiter for AFU requesters, with an order FIFO that routes
// in-order CL responses back to the requester that issued each read.
module afu_rd_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ORD_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*58-1:0]  req_addr,
   input  logic [NUM_REQ*6-1:0]   req_len,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   spl_tx_rd_almostfull,
   output logic                   cor_tx_rd_valid,
   output logic [57:0]            cor_tx_rd_addr,
   output logic [5:0]             cor_tx_rd_len,
   input  logic                   io_rx_rd_valid,
   input  logic [511:0]           io_rx_data,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [511:0]           rsp_data,
   output logic                   busy,
   output logic                   err
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned AW = $clog2(ORD_DEPTH);
   localparam int unsigned OW = AW + 1;

   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]      occ_q, occ_d;
   logic [IW-1:0]      ord_idx_q [ORD_DEPTH];
   logic [6:0]         ord_cnt_q [ORD_DEPTH];

   logic               cor_valid_q;
   logic [57:0]        cor_addr_q;
   logic [5:0]         cor_len_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [511:0]       rsp_data_q;
   logic               err_q;

   logic [57:0]        addr_arr [NUM_REQ];
   logic [5:0]         len_arr  [NUM_REQ];
   logic               gnt_found;
   logic [IW-1:0]      gnt_idx;
   logic [IW-1:0]      cand;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [NUM_REQ-1:0] head_oh;
   logic [57:0]        sel_addr;
   logic [5:0]         sel_len;
   logic [6:0]         push_cnt;
   logic [IW-1:0]      head_idx;
   logic [6:0]         head_cnt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               accept;
   logic               rx_hit;
   logic               pop;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[58*g +: 58];
      assign len_arr[g]  = req_len[6*g +: 6];
   end

   // Search starts one past the last grant and wraps, so the last winner has lowest priority.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign fifo_full  = (occ_q == OW'(ORD_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign accept     = reset_n & ~spl_tx_rd_almostfull & ~fifo_full & gnt_found;

   assign gnt_oh    = NUM_REQ'(1) << gnt_idx;
   assign sel_addr  = addr_arr[gnt_idx];
   assign sel_len   = len_arr[gnt_idx];
   assign push_cnt  = (sel_len == '0) ? 7'd64 : {1'b0, sel_len};
   assign req_ready = accept ? gnt_oh : '0;

   assign head_idx = ord_idx_q[rd_ptr_q];
   assign head_cnt = ord_cnt_q[rd_ptr_q];
   assign head_oh  = NUM_REQ'(1) << head_idx;
   assign rx_hit   = io_rx_rd_valid & ~fifo_empty;
   assign pop      = rx_hit & (head_cnt == 7'd1);

   always_comb begin
      rr_ptr_d = accept ? gnt_idx : rr_ptr_q;
      wr_ptr_d = wr_ptr_q + AW'(accept);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      occ_d    = occ_q + OW'(accept) - OW'(pop);
   end

   // Push and head-decrement never hit the same slot: that needs empty (no rx_hit) or full (no accept).
   always_ff @(posedge clk) begin
      if (accept) begin
         ord_idx_q[wr_ptr_q] <= gnt_idx;
         ord_cnt_q[wr_ptr_q] <= push_cnt;
      end
      if (rx_hit) begin
         ord_cnt_q[rd_ptr_q] <= head_cnt - 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q    <= IW'(NUM_REQ - 1);
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         cor_valid_q <= 1'b0;
         cor_addr_q  <= '0;
         cor_len_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         cor_valid_q <= accept;
         if (accept) begin
            cor_addr_q <= sel_addr;
            cor_len_q  <= sel_len;
         end
         rsp_valid_q <= rx_hit ? head_oh : '0;
         if (rx_hit) begin
            rsp_data_q <= io_rx_data;
         end
         if (io_rx_rd_valid && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign cor_tx_rd_valid = cor_valid_q;
   assign cor_tx_rd_addr  = cor_addr_q;
   assign cor_tx_rd_len   = cor_len_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign busy            = ~fifo_empty;
   assign err             = err_q;

endmodule
